// File: rtl/instr_encoder_pkg.sv
// Shared encodings for the instruction encoder: opcodes, functs, request kinds, FSM states.
// Opcode values are common with the control decoder.
package instr_encoder_pkg;

   localparam logic [5:0] OP_RTYPE = 6'd0;
   localparam logic [5:0] OP_BEQ   = 6'd4;
   localparam logic [5:0] OP_ADDI  = 6'd8;
   localparam logic [5:0] OP_SLTI  = 6'd10;

   localparam logic [5:0] FN_ADD = 6'h20;
   localparam logic [5:0] FN_SUB = 6'h22;
   localparam logic [5:0] FN_AND = 6'h24;
   localparam logic [5:0] FN_OR  = 6'h25;
   localparam logic [5:0] FN_SLT = 6'h2A;

   typedef enum logic [2:0] {
      K_ADD  = 3'd0,
      K_SUB  = 3'd1,
      K_AND  = 3'd2,
      K_OR   = 3'd3,
      K_SLT  = 3'd4,
      K_ADDI = 3'd5,
      K_SLTI = 3'd6,
      K_BEQ  = 3'd7
   } kind_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_DONE = 2'd2
   } state_e;

   function automatic logic [31:0] encode(input kind_e kind, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [4:0] rd,
                                          input logic [15:0] imm);
      logic [31:0] w;
      w = '0;
      case (kind)
         K_ADD:  w = {OP_RTYPE, rs, rt, rd, 5'd0, FN_ADD};
         K_SUB:  w = {OP_RTYPE, rs, rt, rd, 5'd0, FN_SUB};
         K_AND:  w = {OP_RTYPE, rs, rt, rd, 5'd0, FN_AND};
         K_OR:   w = {OP_RTYPE, rs, rt, rd, 5'd0, FN_OR};
         K_SLT:  w = {OP_RTYPE, rs, rt, rd, 5'd0, FN_SLT};
         K_ADDI: w = {OP_ADDI, rs, rt, imm};
         K_SLTI: w = {OP_SLTI, rs, rt, imm};
         K_BEQ:  w = {OP_BEQ, rs, rt, imm};
         default: w = '0;
      endcase
      return w;
   endfunction

endpackage

// File: rtl/instr_encoder_fifo.sv
// Synchronous FIFO for encoded words; flush empties it in one edge.
// Pointers carry an extra wrap bit so level is a plain subtraction.
module instr_fifo #(
   parameter int DEPTH = 4,
   parameter int W     = 32,
   localparam int AW   = $clog2(DEPTH)
) (
   input  logic          clk_i,
   input  logic          rst_i,
   input  logic          flush,
   input  logic          push,
   input  logic [W-1:0]  push_data,
   input  logic          pop,
   output logic [W-1:0]  head,
   output logic [AW:0]   level,
   output logic          full,
   output logic          empty
);

   logic [W-1:0] mem [DEPTH];
   logic [AW:0]  wr_ptr, rd_ptr;

   assign level = wr_ptr - rd_ptr;
   assign full  = (level == (AW+1)'(DEPTH));
   assign empty = (level == '0);
   assign head  = mem[rd_ptr[AW-1:0]];

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push && !full) wr_ptr <= wr_ptr + 1'b1;
         if (pop && !empty) rd_ptr <= rd_ptr + 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (push && !full && !flush) mem[wr_ptr[AW-1:0]] <= push_data;
   end

endmodule

// File: rtl/instr_encoder.sv
// Program loader: encodes symbolic instruction requests into MIPS words and
// streams them into instruction memory at consecutive addresses.
module instr_encoder
   import instr_encoder_pkg::*;
#(
   parameter int ADDR_W     = 5,
   parameter int FIFO_DEPTH = 4
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              start_i,
   input  logic              req_valid_i,
   output logic              req_ready_o,
   input  logic [2:0]        req_kind_i,
   input  logic [4:0]        rs_i,
   input  logic [4:0]        rt_i,
   input  logic [4:0]        rd_i,
   input  logic [15:0]       imm_i,
   output logic              mem_we_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   output logic [31:0]       mem_data_o,
   input  logic              mem_ready_i,
   output logic [ADDR_W:0]   count_o,
   output logic              full_o,
   output logic              busy_o
);

   localparam int CAP = 1 << ADDR_W;
   localparam int LW  = $clog2(FIFO_DEPTH) + 1;

   state_e          state;
   logic [ADDR_W:0] count;
   logic [31:0]     word, head;
   logic [LW-1:0]   level;
   logic            fifo_full, fifo_empty, push, pop;

   assign word = encode(kind_e'(req_kind_i), rs_i, rt_i, rd_i, imm_i);

   // Words already buffered count against capacity so acceptance never over-commits.
   assign req_ready_o = (state == ST_LOAD) && !start_i && !fifo_full &&
                        (32'(count) + 32'(level) < CAP);
   assign push        = req_valid_i && req_ready_o;
   assign mem_we_o    = !fifo_empty && (state != ST_IDLE) && !start_i;
   assign pop         = mem_we_o && mem_ready_i;
   assign mem_data_o  = mem_we_o ? head : '0;
   assign mem_addr_o  = count[ADDR_W-1:0];
   assign count_o     = count;
   assign full_o      = (state == ST_DONE);
   assign busy_o      = (state == ST_LOAD) || !fifo_empty;

   instr_fifo #(.DEPTH(FIFO_DEPTH), .W(32)) u_fifo (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .flush     (start_i),
      .push      (push),
      .push_data (word),
      .pop       (pop),
      .head      (head),
      .level     (level),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state <= ST_IDLE;
         count <= '0;
      end else if (start_i) begin
         state <= ST_LOAD;
         count <= '0;
      end else if (pop) begin
         count <= count + 1'b1;
         if (count == (ADDR_W+1)'(CAP - 1)) state <= ST_DONE;
      end
   end

endmodule

// File: doc/instr_encoder.md
Name: instr_encoder

Overview:
- Inverse of the control decoder: takes symbolic instruction requests (operation kind plus register and immediate fields) and encodes them into 32-bit MIPS words.
- Streams the encoded words into instruction memory at consecutive word addresses.
- Used as the program loader in front of the single-cycle CPU's instruction memory for self-checking test programs.
- Valid/ready request side; buffered write side with memory backpressure.

Parameters:
- ADDR_W, 5, word-address width; program capacity is 2^ADDR_W words.
- FIFO_DEPTH, 4, encoded-word buffer entries (power of two, ≥2).

Ports:
- clk_i  in  1  clock, all state on rising edge
- rst_i  in  1  asynchronous reset, active-low
- start_i  in  1  begin new program: flush buffer, address to 0, enter LOAD
- req_valid_i  in  1  request present
- req_ready_o  out  1  request accepted this cycle when valid&ready
- req_kind_i  in  3  0 ADD, 1 SUB, 2 AND, 3 OR, 4 SLT, 5 ADDI, 6 SLTI, 7 BEQ
- rs_i  in  5  source register
- rt_i  in  5  second source / I-type destination
- rd_i  in  5  R-type destination (ignored for kinds 5-7)
- imm_i  in  16  immediate / branch offset (ignored for kinds 0-4)
- mem_we_o  out  1  write request to instruction memory
- mem_addr_o  out  ADDR_W  word address of the write
- mem_data_o  out  32  encoded instruction
- mem_ready_i  in  1  memory accepts write this cycle
- count_o  out  ADDR_W+1  words written since last start_i
- full_o  out  1  capacity reached (state DONE)
- busy_o  out  1  state LOAD or buffer non-empty

Behaviour:
- Reset (rst_i low, asynchronous):
  - state IDLE; buffer empty; address 0; count_o 0.
  - req_ready_o, mem_we_o, full_o and busy_o are all 0; mem_data_o is 0.
- Encoding, combinational at acceptance:
  - R-type: {6'd0, rs, rt, rd, 5'd0, funct}; funct ADD 0x20, SUB 0x22, AND 0x24, OR 0x25, SLT 0x2A.
  - I-type: {op, rs, rt, imm}; op ADDI 8, SLTI 10, BEQ 4.
- States:
  - IDLE: req_ready_o=0, no writes.
  - LOAD: accept requests and drain the buffer.
  - DONE: full_o=1, req_ready_o=0.
- Transitions:
  - start_i from any state → LOAD.
  - LOAD → DONE on the write that makes count_o = 2^ADDR_W.
  - Only start_i or reset leaves DONE.
- req_ready_o = (state==LOAD) & !start_i & buffer not full & (count_o + buffer level < 2^ADDR_W).
  - The request side can never over-commit capacity.
- Accepted word enters the registered buffer. Earliest appearance on mem_we_o/mem_data_o is the next cycle (1-cycle latency).
- Write side:
  - mem_we_o = buffer non-empty & state != IDLE & !start_i.
  - A write completes on a cycle with mem_we_o & mem_ready_i; on that edge: pop, address+1, count_o+1.
  - While mem_ready_i=0, mem_we_o, mem_addr_o and mem_data_o hold stable.
- Simultaneous push and pop: allowed at any level below full; level unchanged.
  - At full, ready is low, so there is no push; no bypass path.
- start_i with req_valid_i in the same cycle: start wins, request not accepted, no write issued that cycle.
- start_i mid-stream: pending buffered words are discarded, not written; count_o and address go to 0 on that edge.
- Address never wraps. DONE is entered exactly at capacity, and no write occurs after it.
- Reset mid-write: the in-flight write is abandoned; memory content is unspecified for that address.

Decomposition:
- Shared package/include holds:
  - opcode localparams (OP_RTYPE 0, OP_BEQ 4, OP_ADDI 8, OP_SLTI 10), common with the control decoder;
  - funct localparams;
  - req_kind encodings;
  - state encodings.
- One sub-module: instr_fifo, a synchronous FIFO (FIFO_DEPTH x 32, push/pop, level, full/empty) sharing clk_i/rst_i.

Test Plan:
- start_i, then ADD rs=1 rt=2 rd=3 with mem_ready_i=1 → mem_we_o the next cycle, addr 0, data 0x00221820, count_o 1.
- Sequence ADDI rs=0 rt=4 imm=0xFFFF; SLTI rs=5 rt=6 imm=0x0010; BEQ rs=1 rt=2 imm=3 → data 0x2004FFFF, 0x28A60010, 0x10220003 at addresses 0, 1, 2.
- mem_ready_i=0 for 10 cycles while pushing continuously → 4 accepted, then req_ready_o=0; mem_addr_o/mem_data_o stable. After release, all 4 are written in order, one per cycle.
- ADDR_W=2: push 6 requests → only 4 accepted, full_o=1 after the 4th write, req_ready_o stays 0. Then start_i → count_o 0, state LOAD.
- start_i asserted with 3 words buffered and mem_ready_i=0 → buffer flushed, no writes of those words, next accepted word written at address 0.
- rst_i pulled low asynchronously mid-stream (between edges) → all outputs 0 immediately. After release, state IDLE and req_ready_o=0 until start_i.
